// File: rtl/down_timer_8b.sv
// Loadable down-counting timer with one-shot or auto-reload operation,
// a one-cycle done pulse on expiry and a saturating expiry tally.
module down_timer_8b #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TALLY_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               start,
    input  logic               stop,
    input  logic               en,
    input  logic               periodic,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               done,
    output logic [TALLY_W-1:0] tally
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    localparam logic [WIDTH-1:0]   COUNT_ONE = WIDTH'(1);
    localparam logic [TALLY_W-1:0] TALLY_ONE = TALLY_W'(1);

    state_e             state_q,  state_d;
    logic [WIDTH-1:0]   count_q,  count_d;
    logic [WIDTH-1:0]   reload_q, reload_d;
    logic               mode_q,   mode_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [TALLY_W-1:0] tally_q,  tally_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tally_d  = tally_q;

        // stop outranks start in both states; in IDLE it simply leaves everything untouched
        if (stop) begin
            if (state_q == RUN) begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        end else if (start) begin
            if (load_val != '0) begin
                count_d  = load_val;
                reload_d = load_val;
                mode_d   = periodic;
                tally_d  = '0;
                state_d  = RUN;
                busy_d   = 1'b1;
            end else begin
                count_d  = '0;
                done_d   = 1'b1;
                tally_d  = TALLY_ONE;
                state_d  = IDLE;
                busy_d   = 1'b0;
            end
        end else if (state_q == RUN && en) begin
            if (count_q == COUNT_ONE) begin
                done_d  = 1'b1;
                tally_d = (tally_q != '1) ? tally_q + TALLY_ONE : tally_q;
                if (mode_q) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end else if (count_q > COUNT_ONE) begin
                count_d = count_q - COUNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tally_q  <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tally_q  <= tally_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign tally = tally_q;

endmodule

// File: tb/tb_down_timer_8b.sv
// Directed and randomized checks of down_timer_8b against a behavioural
// timer model that tracks remaining ticks, reload value and expiry tally.
module tb_down_timer_8b;

    logic       clk;
    logic       rst;
    logic [7:0] load_val;
    logic       start;
    logic       stop;
    logic       en;
    logic       periodic;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic [7:0] tally;

    int unsigned total;
    int unsigned passed;

    // reference model state
    bit m_run;
    int m_left;
    int m_reload;
    bit m_auto;
    bit m_done;
    int m_tally;

    down_timer_8b #(
        .WIDTH  (8),
        .TALLY_W(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load_val(load_val),
        .start   (start),
        .stop    (stop),
        .en      (en),
        .periodic(periodic),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .tally   (tally)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_run = 0; m_left = 0; m_reload = 0; m_auto = 0; m_done = 0; m_tally = 0;
    endtask

    task automatic model_arm(input int lv, input bit per);
        if (lv != 0) begin
            m_run = 1; m_left = lv; m_reload = lv; m_auto = per; m_tally = 0;
        end else begin
            m_run = 0; m_left = 0; m_done = 1; m_tally = 1;
        end
    endtask

    task automatic model_edge();
        m_done = 0;
        if (stop) begin
            m_run = 0;
        end else if (start) begin
            model_arm(int'(load_val), periodic);
        end else if (m_run && en) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done  = 1;
                m_tally = (m_tally < 255) ? m_tally + 1 : 255;
                if (m_auto) m_left = m_reload;
                else        m_run  = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(m_left));
        chk({tag, ".busy"},  32'(busy),  32'(m_run));
        chk({tag, ".done"},  32'(done),  32'(m_done));
        chk({tag, ".tally"}, 32'(tally), 32'(m_tally));
    endtask

    // one clock edge: advance model, then sample DUT 1ns later
    task automatic tick(input string tag);
        @(posedge clk);
        if (rst) model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic drive(input bit s, input bit p, input bit e, input bit per, input logic [7:0] lv);
        start = s; stop = p; en = e; periodic = per; load_val = lv;
    endtask

    int cyc;
    bit seen;

    initial begin
        total = 0; passed = 0;
        rst = 1'b0;
        drive(0, 0, 0, 0, 8'd0);
        model_reset();
        repeat (2) tick("reset");
        @(negedge clk); rst = 1'b1;
        tick("post_reset");

        // one-shot load 5
        drive(1, 0, 1, 0, 8'd5);
        tick("os_start");
        chk("os_start_count", 32'(count), 32'd5);
        drive(0, 0, 1, 1, 8'd77);
        for (int i = 4; i >= 0; i--) tick("os_run");
        chk("os_done", 32'(done), 32'd1);
        chk("os_busy_low", 32'(busy), 32'd0);
        chk("os_tally", 32'(tally), 32'd1);
        tick("os_after");
        chk("os_done_pulse", 32'(done), 32'd0);

        // periodic load 3
        drive(1, 0, 1, 1, 8'd3);
        tick("per_start");
        drive(0, 0, 1, 0, 8'd9);
        repeat (9) tick("per_run");
        chk("per_tally9", 32'(tally), 32'd3);
        chk("per_busy", 32'(busy), 32'd1);
        chk("per_count", 32'(count), 32'd3);
        drive(0, 1, 1, 0, 8'd0);
        tick("per_stop");

        // en gap of 4 cycles delays expiry to 14 edges
        drive(1, 0, 1, 0, 8'd10);
        tick("en_start");
        drive(0, 0, 1, 0, 8'd0);
        cyc = 0; seen = 0;
        while (!seen && cyc < 40) begin
            en = !(cyc >= 3 && cyc < 7);
            tick("en_run");
            cyc++;
            seen = done;
        end
        chk("en_expiry_cycle", 32'(cyc), 32'd14);

        // stop at count 4, then short restart
        drive(1, 0, 1, 0, 8'd8);
        tick("stop_start");
        drive(0, 0, 1, 0, 8'd0);
        repeat (4) tick("stop_run");
        chk("stop_pre_count", 32'(count), 32'd4);
        stop = 1'b1;
        tick("stop_edge");
        chk("stop_count_hold", 32'(count), 32'd4);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_done", 32'(done), 32'd0);
        stop = 1'b0;
        tick("stop_idle");
        drive(1, 0, 1, 0, 8'd2);
        tick("restart");
        start = 1'b0;
        tick("restart_1");
        tick("restart_2");
        chk("restart_done", 32'(done), 32'd1);

        // zero load
        drive(1, 0, 1, 0, 8'd0);
        tick("zero_start");
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_tally", 32'(tally), 32'd1);
        start = 1'b0;
        tick("zero_after");

        // asynchronous reset mid-run at count 6
        drive(1, 0, 1, 0, 8'd8);
        tick("rst_start");
        start = 1'b0;
        repeat (2) tick("rst_run");
        chk("rst_pre_count", 32'(count), 32'd6);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check_model("rst_async");
        @(negedge clk); rst = 1'b1;
        tick("rst_release");

        // periodic load 1 saturates tally
        drive(1, 0, 1, 1, 8'd1);
        tick("sat_start");
        start = 1'b0;
        repeat (300) tick("sat_run");
        chk("sat_tally", 32'(tally), 32'd255);
        chk("sat_count", 32'(count), 32'd1);
        stop = 1'b1;
        tick("sat_stop");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive(0, 0, ($urandom_range(0, 99) < 85), $urandom_range(0, 1),
                  8'($urandom_range(0, 12)));
            if ($urandom_range(0, 11) == 0)       start = 1'b1;
            else if ($urandom_range(0, 29) == 0)  stop  = 1'b1;
            tick("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
